// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
// Shared types and helpers for the multiplier-sharing arbiter.
//   owner_w()  : width of a requester index for a given requester count
//   tag_t      : {valid, owner} record that rides alongside the multiplier
//   pipe_lat() : handshake-to-result-visible latency in cycles (LEVEL+3)
// No ports (package).
// -----------------------------------------------------------------------------
package mult_arb_pkg;

  // Requester count is limited to 8, so an owner index never needs more
  // than 3 bits; the tag struct carries the widest case.
  localparam int OWNER_W_MAX = 3;

  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [OWNER_W_MAX-1:0] owner;
  } tag_t;

  function automatic int pipe_lat(input int level);
    return level + 3;
  endfunction

endpackage

// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
// Unsigned pipelined multiplier: one input register stage followed by LEVEL
// output stages, so o_pdt reflects i_a/i_b presented LEVEL+1 cycles earlier.
// No reset: contents are qualified externally by the owner tag pipe.
// Ports:
//   i_clk  clock
//   i_a    operand A (WIDTH)
//   i_b    operand B (WIDTH)
//   o_pdt  full-width product (2*WIDTH)
// -----------------------------------------------------------------------------
module multiplier #(
  parameter int WIDTH = 40,
  parameter int LEVEL = 6
) (
  input  logic               i_clk,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_pdt
);

  logic [WIDTH-1:0]   r_a_p0;
  logic [WIDTH-1:0]   r_b_p0;
  logic [2*WIDTH-1:0] r_pdt_p [LEVEL];

  always_ff @(posedge i_clk) begin
    // stage p0: operand capture
    r_a_p0 <= i_a;
    r_b_p0 <= i_b;
    // stage p1: full-width unsigned product
    r_pdt_p[0] <= {{WIDTH{1'b0}}, r_a_p0} * {{WIDTH{1'b0}}, r_b_p0};
    // stages p2..: retiming/output stages
    for (int s = 1; s < LEVEL; s++) begin
      r_pdt_p[s] <= r_pdt_p[s-1];
    end
  end

  assign o_pdt = r_pdt_p[LEVEL-1];

endmodule

// File: rtl/rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Combinational round-robin picker. Search starts one past i_last and wraps
// modulo NUM_REQ; the first eligible requester found is granted.
// Ports:
//   i_elig   eligible vector (NUM_REQ)
//   i_last   index of the most recent grant (IDX_W)
//   o_grant  one-hot grant, or zero when nothing is eligible
// -----------------------------------------------------------------------------
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant
);

  int   w_last;
  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_last  = int'(i_last);
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && i_elig[j] && (((w_last + off) % NUM_REQ) == j)) begin
          o_grant[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
// Time-shares one pipelined multiplier among NUM_REQ requesters. Each
// requester has a valid/ready operand port and a valid/ready result port and
// may have at most one operation outstanding (in flight or parked in its
// result register), so result storage can never overflow.
// Optional feature macro: MULT_ARB_STATS_EN adds issue/conflict counters.
// Ports:
//   clk_in            clock, rising edge
//   rst_n_in          asynchronous active-low reset
//   req_valid_in      operand valid per requester
//   req_ready_out     one-hot grant (operand ready)
//   req_a_in/req_b_in packed operands, requester i at [i*WIDTH +: WIDTH]
//   res_valid_out     result held per requester
//   res_ready_in      result consumed per requester
//   res_pdt_out       packed products, requester i at [i*2*WIDTH +: 2*WIDTH]
//   issue_cnt_out     operand handshakes (MULT_ARB_STATS_EN only)
//   conflict_cnt_out  cycles with >=2 eligible requesters (MULT_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH   = 40,
  parameter int LEVEL   = 6,
  parameter int NUM_REQ = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a_in,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b_in,
  output logic [NUM_REQ-1:0]         res_valid_out,
  input  logic [NUM_REQ-1:0]         res_ready_in,
  output logic [NUM_REQ*2*WIDTH-1:0] res_pdt_out
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [31:0]                issue_cnt_out,
  output logic [31:0]                conflict_cnt_out
`endif
);

  localparam int OW = owner_w(NUM_REQ);

  logic [NUM_REQ-1:0]     r_busy;
  logic [NUM_REQ-1:0]     r_res_vld;
  logic [OW-1:0]          r_last;
  tag_t                   r_tag [LEVEL+2];
  logic [2*WIDTH-1:0]     r_pdt [NUM_REQ];
  logic [WIDTH-1:0]       r_a_iss;
  logic [WIDTH-1:0]       r_b_iss;

  logic [NUM_REQ-1:0]     w_elig;
  logic [NUM_REQ-1:0]     w_grant;
  logic                   w_hs_any;
  logic [OWNER_W_MAX-1:0] w_sel_idx;
  logic [WIDTH-1:0]       w_a_sel;
  logic [WIDTH-1:0]       w_b_sel;
  logic [2*WIDTH-1:0]     w_mult_pdt;
  tag_t                   w_tag_out;
  logic [NUM_REQ-1:0]     w_wr;
  logic [NUM_REQ-1:0]     w_acc;

  // Gating with rst_n_in keeps the grant low while reset is held, even if
  // requesters are already presenting valid operands.
  assign w_elig = req_valid_in & ~r_busy & ~r_res_vld & {NUM_REQ{rst_n_in}};

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OW)
  ) u_rr_grant (
    .i_elig  (w_elig),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  // Grant is a subset of eligibility, which already includes valid, so any
  // grant bit is a completed handshake.
  assign req_ready_out = w_grant;
  assign w_hs_any      = |w_grant;

  always_comb begin
    w_sel_idx = '0;
    w_a_sel   = '0;
    w_b_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_idx = OWNER_W_MAX'(i);
      end
      w_a_sel = w_a_sel | ({WIDTH{w_grant[i]}} & req_a_in[i*WIDTH +: WIDTH]);
      w_b_sel = w_b_sel | ({WIDTH{w_grant[i]}} & req_b_in[i*WIDTH +: WIDTH]);
    end
  end

  assign w_tag_out = r_tag[LEVEL+1];

  always_comb begin
    w_wr  = '0;
    w_acc = r_res_vld & res_ready_in;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_wr[i] = w_tag_out.valid && (w_tag_out.owner == OWNER_W_MAX'(i));
    end
  end

  // Issue operand registers: data only, qualified by r_tag[0].valid.
  always_ff @(posedge clk_in) begin
    if (w_hs_any) begin
      r_a_iss <= w_a_sel;
      r_b_iss <= w_b_sel;
    end
  end

  multiplier #(
    .WIDTH (WIDTH),
    .LEVEL (LEVEL)
  ) u_multiplier (
    .i_clk (clk_in),
    .i_a   (r_a_iss),
    .i_b   (r_b_iss),
    .o_pdt (w_mult_pdt)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy    <= '0;
      r_res_vld <= '0;
      r_last    <= OW'(NUM_REQ - 1);
      for (int s = 0; s < LEVEL + 2; s++) begin
        r_tag[s] <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        r_pdt[i] <= '0;
      end
    end else begin
      // tag stage 0 sits beside the issue registers; stage LEVEL+1 lines up
      // with the multiplier output
      r_tag[0].valid <= w_hs_any;
      r_tag[0].owner <= w_sel_idx;
      for (int s = 1; s < LEVEL + 2; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
      if (w_hs_any) begin
        r_last <= w_sel_idx[OW-1:0];
      end
      // A requester with an op in flight is never granted and never has a
      // pending result, so set/clear below never target the same bit.
      r_busy    <= (r_busy | w_grant) & ~w_wr;
      r_res_vld <= (r_res_vld & ~w_acc) | w_wr;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_wr[i]) begin
          r_pdt[i] <= w_mult_pdt;
        end
      end
    end
  end

  assign res_valid_out = r_res_vld;

  always_comb begin
    res_pdt_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      res_pdt_out[i*2*WIDTH +: 2*WIDTH] = r_pdt[i];
    end
  end

`ifdef MULT_ARB_STATS_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_issue_cnt    <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_hs_any) begin
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
      if ($countones(w_elig) >= 2) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
    end
  end

  assign issue_cnt_out    = r_issue_cnt;
  assign conflict_cnt_out = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  localparam int W   = 40;
  localparam int L   = 6;
  localparam int N   = 4;
  localparam int LAT = L + 3;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   res_valid;
  logic [N-1:0]   res_ready;
  logic [N*2*W-1:0] res_pdt;
`ifdef MULT_ARB_STATS_EN
  logic [31:0]    issue_cnt;
  logic [31:0]    conflict_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mult_share_arbiter #(.WIDTH(W), .LEVEL(L), .NUM_REQ(N)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .req_a_in      (req_a),
    .req_b_in      (req_b),
    .res_valid_out (res_valid),
    .res_ready_in  (res_ready),
    .res_pdt_out   (res_pdt)
`ifdef MULT_ARB_STATS_EN
    ,
    .issue_cnt_out    (issue_cnt),
    .conflict_cnt_out (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t tv [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] pdt_of(input int r);
    return res_pdt[r*2*W +: 2*W];
  endfunction

  // One complete operation on a single requester with timing checks.
  task automatic do_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] p);
    int   lat;
    logic got;
    logic [N-1:0] onehot;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_valid[r]    = 1'b1;
    #1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_ready[r]) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("op_grant", 80'(got), 80'd1);
    if (!got) begin
      req_valid[r] = 1'b0;
      return;
    end
    onehot = N'(1) << r;
    chk("op_grant_onehot", 80'(req_ready), 80'(onehot));
    step();
    req_valid[r] = 1'b0;
    lat = 1;
    while (!res_valid[r] && lat < 30) begin
      step();
      lat++;
    end
    chk("op_latency", 80'(lat), 80'(LAT));
    chk("op_product", pdt_of(r), p);
    res_ready[r] = 1'b1;
    step();
    chk("op_valid_drop", 80'(res_valid[r]), 80'd0);
    res_ready[r] = 1'b0;
  endtask

  initial begin
    int   others;
    logic seen2;
    logic found;
    logic any_vld;

    tv[0] = '{0, 40'd3, 40'd5, 80'd15};
    tv[1] = '{1, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 80'hFFFF_FFFF_FE00_0000_0001};
    tv[2] = '{2, 40'd0, 40'd12345, 80'd0};
    tv[3] = '{3, 40'h80_0000_0000, 40'd2, 80'h100_0000_0000};
    tv[4] = '{0, 40'h1_2345_6789, 40'h1000, 80'h1234_5678_9000};
    tv[5] = '{1, 40'd1000000, 40'd1000000, 80'hE8_D4A5_1000};

    // reset state, with every requester already presenting operands
    rst_n     = 1'b0;
    res_ready = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 2);
      req_b[i*W +: W] = W'(i + 10);
    end
    req_valid = '1;
    #2;
    chk("rst_ready", 80'(req_ready), 80'd0);
    chk("rst_res_valid", 80'(res_valid), 80'd0);
    chk("rst_pdt0", pdt_of(0), 80'd0);
    chk("rst_pdt3", pdt_of(3), 80'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;

    // contention: grants 0,1,2,3 on consecutive cycles
    chk("cont_g0", 80'(req_ready), 80'b0001);
    step();
    chk("cont_g1", 80'(req_ready), 80'b0010);
    step();
    chk("cont_g2", 80'(req_ready), 80'b0100);
    step();
    chk("cont_g3", 80'(req_ready), 80'b1000);
    step();
    chk("cont_g_none", 80'(req_ready), 80'd0);
    for (int i = 0; i < 4; i++) step();
    chk("cont_res_k8", 80'(res_valid), 80'd0);
    step();
    chk("cont_res_k9", 80'(res_valid), 80'b0001);
    step();
    chk("cont_res_k10", 80'(res_valid), 80'b0011);
    step();
    chk("cont_res_k11", 80'(res_valid), 80'b0111);
    step();
    chk("cont_res_k12", 80'(res_valid), 80'b1111);
    chk("cont_pdt0", pdt_of(0), 80'd20);
    chk("cont_pdt1", pdt_of(1), 80'd33);
    chk("cont_pdt2", pdt_of(2), 80'd48);
    chk("cont_pdt3", pdt_of(3), 80'd65);
`ifdef MULT_ARB_STATS_EN
    chk("cont_conflicts", 80'(conflict_cnt), 80'd3);
    chk("cont_issues", 80'(issue_cnt), 80'd4);
`endif

    // backpressure: requester 2 keeps its result, others keep cycling
    res_ready = 4'b1011;
    seen2  = 1'b0;
    others = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_ready[2]) seen2 = 1'b1;
      if (req_ready[0] || req_ready[1] || req_ready[3]) others++;
    end
    chk("bp_block2", 80'(seen2), 80'd0);
    chk("bp_others_granted", 80'(others >= 3), 80'd1);
    chk("bp_res2_held", 80'(res_valid[2]), 80'd1);
    res_ready[2] = 1'b1;
    step();
    res_ready[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_ready[2]) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("bp_release_grant2", 80'(found), 80'd1);
    step();
    req_valid = '0;
    for (int i = 0; i < 12 && !res_valid[2]; i++) step();
    chk("bp_res2_back", 80'(res_valid[2]), 80'd1);
    chk("bp_pdt2", pdt_of(2), 80'd48);
    res_ready = '1;
    for (int i = 0; i < 15; i++) step();
    chk("bp_drained", 80'(res_valid), 80'd0);
    res_ready = '0;

    // table-driven single operations
    for (int t = 0; t < 6; t++) begin
      do_op(tv[t].r, tv[t].a, tv[t].b, tv[t].p);
    end

    // reset while an op is in flight
    req_a[1*W +: W] = 40'd7;
    req_b[1*W +: W] = 40'd9;
    req_valid[1]    = 1'b1;
    #1;
    chk("mid_grant", 80'(req_ready), 80'b0010);
    step();
    req_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    any_vld = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (res_valid != '0) any_vld = 1'b1;
    end
    chk("mid_no_result", 80'(any_vld), 80'd0);
    do_op(1, 40'd7, 40'd9, 80'd63);

`ifdef MULT_ARB_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("stats_rst_issue", 80'(issue_cnt), 80'd0);
    for (int i = 0; i < 100; i++) begin
      do_op(0, W'(i), 40'd3, 80'(i * 3));
    end
    chk("stats_issue100", 80'(issue_cnt), 80'd100);
    chk("stats_conflict0", 80'(conflict_cnt), 80'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
